// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares the single L2-to-DRAM burst port between the line-fill engine
// (reads) and the writeback buffer (writes); each grant runs one full-line burst.
module l2_mem_arbiter #(
   parameter int BEATS      = 4,
   parameter int LINE_OFF   = 5,
   parameter int MAX_STREAK = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fill_req,
   input  logic [31:0]              fill_addr,
   output logic [63:0]              fill_data,
   output logic                     fill_beat_vld,
   output logic [$clog2(BEATS)-1:0] fill_beat,
   output logic                     fill_done,
   input  logic                     wb_req,
   input  logic [31:0]              wb_addr,
   input  logic [63:0]              wb_data,
   output logic                     wb_beat_rd,
   output logic                     wb_done,
   output logic                     mem_req,
   output logic                     mem_cmd,
   output logic [31:0]              mem_addr,
   output logic [63:0]              mem_wdata,
   input  logic [63:0]              mem_rdata,
   input  logic                     mem_strobe,
   output logic                     busy
);
   localparam int BW = $clog2(BEATS);
   localparam int SW = $clog2(MAX_STREAK + 1);
   localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [31:0]   addr_q, addr_d;
   logic          gnt_wb_q, gnt_wb_d;
   logic          same_line;
   logic          pick_wb;

   function automatic logic [31:0] line_align(input logic [31:0] a);
      return {a[31:LINE_OFF], {LINE_OFF{1'b0}}};
   endfunction

   function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
      return (s == STREAK_MAX) ? s : s + SW'(1);
   endfunction

   // A pending writeback to the line being filled must land first or the fill reads stale data.
   assign same_line = fill_addr[31:LINE_OFF] == wb_addr[31:LINE_OFF];
   assign pick_wb   = wb_req && (!fill_req || streak_q == STREAK_MAX || same_line);

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      streak_d = streak_q;
      addr_d   = addr_q;
      gnt_wb_d = gnt_wb_q;
      case (state_q)
         IDLE: begin
            if (pick_wb) begin
               state_d  = WR;
               gnt_wb_d = 1'b1;
               addr_d   = line_align(wb_addr);
               streak_d = '0;
            end else if (fill_req) begin
               state_d  = RD;
               gnt_wb_d = 1'b0;
               addr_d   = line_align(fill_addr);
               if (wb_req) streak_d = sat_inc(streak_q);
            end
         end
         RD, WR: begin
            if (mem_strobe) begin
               beat_d = beat_q + BW'(1);
               if (beat_q == LAST_BEAT) state_d = DONE;
            end
         end
         DONE: begin
            beat_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         streak_q <= '0;
         addr_q   <= '0;
         gnt_wb_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         streak_q <= streak_d;
         addr_q   <= addr_d;
         gnt_wb_q <= gnt_wb_d;
      end
   end

   // Beat-level outputs follow the strobe combinationally; everything else decodes the state flops.
   assign busy          = state_q != IDLE;
   assign mem_req       = (state_q == RD) || (state_q == WR);
   assign mem_cmd       = state_q == WR;
   assign mem_addr      = addr_q;
   assign mem_wdata     = (state_q == WR) ? wb_data : '0;
   assign wb_beat_rd    = (state_q == WR) && mem_strobe;
   assign fill_data     = (state_q == RD) ? mem_rdata : '0;
   assign fill_beat_vld = (state_q == RD) && mem_strobe;
   assign fill_beat     = (state_q == RD) ? beat_q : '0;
   assign fill_done     = (state_q == DONE) && !gnt_wb_q;
   assign wb_done       = (state_q == DONE) && gnt_wb_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: acts as both L2 requesters and the DRAM, checking every cycle
// against a queue-based model of the grant rules.
module tb_l2_mem_arbiter;
   localparam int BEATS      = 4;
   localparam int LINE_OFF   = 5;
   localparam int MAX_STREAK = 4;
   localparam int BW         = $clog2(BEATS);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fill_req;
   logic [31:0]   fill_addr;
   logic [63:0]   fill_data;
   logic          fill_beat_vld;
   logic [BW-1:0] fill_beat;
   logic          fill_done;
   logic          wb_req;
   logic [31:0]   wb_addr;
   logic [63:0]   wb_data;
   logic          wb_beat_rd;
   logic          wb_done;
   logic          mem_req;
   logic          mem_cmd;
   logic [31:0]   mem_addr;
   logic [63:0]   mem_wdata;
   logic [63:0]   mem_rdata;
   logic          mem_strobe;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int m_streak = 0;
   logic [31:0] fq[$];
   logic [31:0] wq[$];

   l2_mem_arbiter #(.BEATS(BEATS), .LINE_OFF(LINE_OFF), .MAX_STREAK(MAX_STREAK)) dut (
      .clk(clk), .rst_n(rst_n),
      .fill_req(fill_req), .fill_addr(fill_addr), .fill_data(fill_data),
      .fill_beat_vld(fill_beat_vld), .fill_beat(fill_beat), .fill_done(fill_done),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_beat_rd(wb_beat_rd), .wb_done(wb_done),
      .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_strobe(mem_strobe), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] line_of(input logic [31:0] a);
      return (a >> LINE_OFF) << LINE_OFF;
   endfunction

   // Grant rules in priority order; also tracks how many fills have overtaken a waiting writeback.
   function automatic bit model_pick(input bit fr, input bit wr, input logic [31:0] fa,
                                     input logic [31:0] wa);
      bit w;
      if (!wr)                                  w = 1'b0;
      else if (!fr)                             w = 1'b1;
      else if (m_streak == MAX_STREAK)          w = 1'b1;
      else if ((fa >> LINE_OFF) == (wa >> LINE_OFF)) w = 1'b1;
      else                                      w = 1'b0;
      if (w) m_streak = 0;
      else if (wr && m_streak < MAX_STREAK) m_streak++;
      return w;
   endfunction

   task automatic chk_burst(input string tag, input bit exp_wb, input logic [31:0] exp_addr);
      chk({tag, "_mem_req"}, 64'(mem_req), 64'(1));
      chk({tag, "_mem_cmd"}, 64'(mem_cmd), 64'(exp_wb));
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(exp_addr));
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      chk({tag, "_fill_done"}, 64'(fill_done), 64'(0));
      chk({tag, "_wb_done"}, 64'(wb_done), 64'(0));
   endtask

   // Drives one granted burst starting the cycle after the grant edge, ending in the done cycle.
   task automatic serve_burst(input bit exp_wb, input logic [31:0] exp_addr, input int gap,
                              input bit seq, input logic [63:0] base);
      logic [63:0] rd;
      logic [63:0] wd;
      int ng;
      for (int b = 0; b < BEATS; b++) begin
         ng = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
         for (int g = 0; g < ng; g++) begin
            tick();
            mem_strobe = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            wb_data    = {$urandom, $urandom};
            @(negedge clk);
            chk_burst("gap", exp_wb, exp_addr);
            chk("gap_vld", 64'(fill_beat_vld), 64'(0));
            chk("gap_rd", 64'(wb_beat_rd), 64'(0));
         end
         rd = seq ? base + 64'(b) : {$urandom, $urandom};
         wd = {$urandom, $urandom};
         tick();
         mem_strobe = 1'b1;
         mem_rdata  = rd;
         wb_data    = wd;
         @(negedge clk);
         chk_burst("beat", exp_wb, exp_addr);
         chk("beat_vld", 64'(fill_beat_vld), 64'(!exp_wb));
         chk("beat_rd", 64'(wb_beat_rd), 64'(exp_wb));
         if (!exp_wb) begin
            chk("fill_beat", 64'(fill_beat), 64'(b));
            chk("fill_data", fill_data, rd);
         end else begin
            chk("mem_wdata", mem_wdata, wd);
         end
      end
      tick();
      mem_strobe = 1'($urandom);
      mem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      chk("done_mem_req", 64'(mem_req), 64'(0));
      chk("done_fill_done", 64'(fill_done), 64'(!exp_wb));
      chk("done_wb_done", 64'(wb_done), 64'(exp_wb));
      chk("done_vld", 64'(fill_beat_vld), 64'(0));
      chk("done_rd", 64'(wb_beat_rd), 64'(0));
      chk("done_busy", 64'(busy), 64'(1));
   endtask

   // Presents queue heads as requests in each idle cycle until both queues drain.
   task automatic run_queues(input int gap, input bit seq, input logic [63:0] base);
      bit fr;
      bit wr;
      bit w;
      logic [31:0] a;
      while (fq.size() > 0 || wq.size() > 0) begin
         tick();
         fr = fq.size() > 0;
         wr = wq.size() > 0;
         fill_req   = fr;
         wb_req     = wr;
         fill_addr  = $urandom;
         wb_addr    = $urandom;
         if (fr) fill_addr = fq[0];
         if (wr) wb_addr = wq[0];
         mem_strobe = 1'($urandom);
         mem_rdata  = {$urandom, $urandom};
         @(negedge clk);
         chk("idle_busy", 64'(busy), 64'(0));
         chk("idle_mem_req", 64'(mem_req), 64'(0));
         chk("idle_vld", 64'(fill_beat_vld), 64'(0));
         chk("idle_rd", 64'(wb_beat_rd), 64'(0));
         w = model_pick(fr, wr, fill_addr, wb_addr);
         if (w) a = wq.pop_front();
         else   a = fq.pop_front();
         serve_burst(w, line_of(a), gap, seq, base);
      end
      tick();
      fill_req   = 1'b0;
      wb_req     = 1'b0;
      mem_strobe = 1'b0;
      @(negedge clk);
      chk("end_busy", 64'(busy), 64'(0));
      chk("end_mem_req", 64'(mem_req), 64'(0));
   endtask

   initial begin
      logic [31:0] t;
      int nf;
      int nw;
      rst_n      = 1'b0;
      fill_req   = 1'b0;
      fill_addr  = '0;
      wb_req     = 1'b0;
      wb_addr    = '0;
      wb_data    = '0;
      mem_rdata  = '0;
      mem_strobe = 1'b0;

      // reset held with random inputs: every output must read zero
      for (int i = 0; i < 4; i++) begin
         tick();
         fill_req   = 1'($urandom);
         fill_addr  = $urandom;
         wb_req     = 1'($urandom);
         wb_addr    = $urandom;
         wb_data    = {$urandom, $urandom};
         mem_rdata  = {$urandom, $urandom};
         mem_strobe = 1'($urandom);
         @(negedge clk);
         chk("rst_fill_data", fill_data, 64'(0));
         chk("rst_fill_beat_vld", 64'(fill_beat_vld), 64'(0));
         chk("rst_fill_beat", 64'(fill_beat), 64'(0));
         chk("rst_fill_done", 64'(fill_done), 64'(0));
         chk("rst_wb_beat_rd", 64'(wb_beat_rd), 64'(0));
         chk("rst_wb_done", 64'(wb_done), 64'(0));
         chk("rst_mem_req", 64'(mem_req), 64'(0));
         chk("rst_mem_cmd", 64'(mem_cmd), 64'(0));
         chk("rst_mem_addr", 64'(mem_addr), 64'(0));
         chk("rst_mem_wdata", mem_wdata, 64'(0));
         chk("rst_busy", 64'(busy), 64'(0));
      end
      tick();
      fill_req   = 1'b0;
      wb_req     = 1'b0;
      mem_strobe = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'(0));

      // stray strobes while idle
      for (int i = 0; i < 3; i++) begin
         tick();
         mem_strobe = 1'b1;
         mem_rdata  = {$urandom, $urandom};
         @(negedge clk);
         chk("stray_vld", 64'(fill_beat_vld), 64'(0));
         chk("stray_rd", 64'(wb_beat_rd), 64'(0));
         chk("stray_busy", 64'(busy), 64'(0));
         chk("stray_mem_req", 64'(mem_req), 64'(0));
      end

      // single fill, one-cycle strobe gaps, sequential read data
      fq.push_back(32'h0000_1234);
      run_queues(1, 1'b1, 64'hA0);

      // simultaneous fill / writeback on different lines
      fq.push_back(32'h0000_1000);
      wq.push_back(32'h0000_2040);
      run_queues(-1, 1'b0, 64'h0);

      // simultaneous fill / writeback on the same line
      fq.push_back(32'h0000_3008);
      wq.push_back(32'h0000_3010);
      run_queues(0, 1'b0, 64'h0);

      // five back-to-back fills against one waiting writeback
      for (int i = 0; i < 5; i++) fq.push_back(32'h0001_0000 + 32'(i * 64));
      wq.push_back(32'h0002_0000);
      run_queues(0, 1'b0, 64'h0);

      // randomized request mixes
      for (int r = 0; r < 8; r++) begin
         nf = int'($urandom_range(3, 0));
         nw = int'($urandom_range(3, 0));
         for (int i = 0; i < nf; i++) fq.push_back($urandom);
         for (int i = 0; i < nw; i++) wq.push_back($urandom);
         if (nf > 0 && nw > 0 && $urandom_range(2, 0) == 0) begin
            t = fq[0];
            wq[0] = {t[31:LINE_OFF], 5'($urandom)};
         end
         run_queues(-1, 1'b0, 64'h0);
      end

      // reset asserted after the second strobe of a write burst
      tick();
      wb_req     = 1'b1;
      wb_addr    = 32'h0000_5048;
      fill_req   = 1'b0;
      mem_strobe = 1'b0;
      @(negedge clk);
      chk("abort_idle_busy", 64'(busy), 64'(0));
      for (int i = 0; i < 2; i++) begin
         tick();
         mem_strobe = 1'b1;
         wb_data    = {$urandom, $urandom};
         @(negedge clk);
         chk("abort_mem_cmd", 64'(mem_cmd), 64'(1));
         chk("abort_mem_addr", 64'(mem_addr), 64'h5040);
         chk("abort_rd", 64'(wb_beat_rd), 64'(1));
      end
      tick();
      mem_strobe = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("abort_mem_req", 64'(mem_req), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_wb_done", 64'(wb_done), 64'(0));
      chk("abort_mem_addr_clr", 64'(mem_addr), 64'(0));
      wb_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge clk);
         chk("abort_hold_wb_done", 64'(wb_done), 64'(0));
         chk("abort_hold_mem_req", 64'(mem_req), 64'(0));
      end
      tick();
      rst_n    = 1'b1;
      m_streak = 0;
      @(negedge clk);
      chk("abort_rel_wb_done", 64'(wb_done), 64'(0));
      chk("abort_rel_busy", 64'(busy), 64'(0));

      // a fresh fill after the abort completes normally
      fq.push_back(32'h0000_6010);
      run_queues(-1, 1'b0, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
